line_memory: RTL and testbench

LINE_MEMORY -- requirements
Module: line_memory

---
 rtl/line_memory.sv | 129 ++++++++++++
 tb/tb_line_memory.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/line_memory.sv
// Line-oriented memory: 64-bit lines behind a fixed-latency read/write handshake.
// Optional posted writes: define LINE_MEMORY_POSTED_WRITE_EN.
module line_memory #(
  parameter int unsigned LATENCY    = 4,
  parameter int unsigned LINE_DEPTH = 256
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        readM,
  input  logic        writeM,
  input  logic [15:0] address,
  inout  logic [63:0] data,
  output logic        ack,
  output logic        busy
);

  localparam int unsigned IDX_W = $clog2(LINE_DEPTH);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_WAIT = 2'd1;
  localparam logic [1:0] S_ACK  = 2'd2;

  // WAIT is entered with the counter at 0, so leaving at LATENCY-2 places
  // ack in the LATENCY-th cycle counted from the one presenting the request.
  localparam logic [3:0] WAIT_LAST = 4'(LATENCY - 2);

  logic [1:0]       state;
  logic [3:0]       cnt;
  logic [IDX_W-1:0] idx;
  logic             is_wr;
  logic [63:0]      wline;
  logic             accept;
  logic             mem_we;
  logic [IDX_W-1:0] req_idx;
  logic             unused_addr;

  logic [63:0] mem [LINE_DEPTH];

  assign req_idx     = address[IDX_W+1:2];
  assign unused_addr = ^{address[15:IDX_W+2], address[1:0]};

`ifdef LINE_MEMORY_POSTED_WRITE_EN
  localparam logic [3:0] DRAIN_LAST = 4'(LATENCY - 1);

  // idx/wline double as the posted-write buffer; nothing else is accepted
  // while it is valid, so the latched fields cannot be overwritten early.
  logic buf_valid;

  assign accept = (state == S_IDLE) && (readM || writeM) && !buf_valid;
  assign busy   = (state != S_IDLE) || buf_valid;
  assign mem_we = buf_valid && (cnt == DRAIN_LAST);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      buf_valid <= 1'b0;
    end else if (accept && writeM) begin
      buf_valid <= 1'b1;
    end else if (mem_we) begin
      buf_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt <= '0;
    end else if (accept) begin
      cnt <= '0;
    end else if ((state == S_WAIT) || buf_valid) begin
      cnt <= cnt + 4'd1;
    end
  end
`else
  assign accept = (state == S_IDLE) && (readM || writeM);
  assign busy   = (state != S_IDLE);
  assign mem_we = (state == S_ACK) && is_wr;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt <= '0;
    end else if (accept) begin
      cnt <= '0;
    end else if (state == S_WAIT) begin
      cnt <= cnt + 4'd1;
    end
  end
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= S_IDLE;
      idx   <= '0;
      is_wr <= 1'b0;
      wline <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (accept) begin
            idx   <= req_idx;
            is_wr <= writeM;
            wline <= data;
`ifdef LINE_MEMORY_POSTED_WRITE_EN
            state <= writeM ? S_ACK : S_WAIT;
`else
            state <= S_WAIT;
`endif
          end
        end
        S_WAIT: begin
          if (cnt == WAIT_LAST) begin
            state <= S_ACK;
          end
        end
        S_ACK:   state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  // Array has no reset; a reset edge suppresses any pending write.
  always_ff @(posedge clk) begin
    if (!reset && mem_we) begin
      mem[idx] <= wline;
    end
  end

  assign ack  = (state == S_ACK);
  assign data = ((state == S_ACK) && !is_wr) ? mem[idx] : 'z;

endmodule

// File: tb/tb_line_memory.sv
// Self-checking bench for line_memory: vector table, corner sequences and
// randomized traffic checked against an array model of the line store.
module tb_line_memory;

  localparam int unsigned LAT   = 4;
  localparam int unsigned DEPTH = 256;
  localparam logic [63:0] PROBE = 64'h5A5A_C3C3_0F0F_9696;

  logic        clk = 1'b0;
  logic        reset;
  logic        readM;
  logic        writeM;
  logic [15:0] address;
  wire  [63:0] data;
  logic [63:0] tb_drv;
  logic        tb_oe;
  logic        ack;
  logic        busy;

  assign data = tb_oe ? tb_drv : 'z;

  always #5 clk = ~clk;

  line_memory #(.LATENCY(LAT), .LINE_DEPTH(DEPTH)) dut (
    .clk    (clk),
    .reset  (reset),
    .readM  (readM),
    .writeM (writeM),
    .address(address),
    .data   (data),
    .ack    (ack),
    .busy   (busy)
  );

  int checks   = 0;
  int failures = 0;
  int wr_lat;

  logic [63:0] model [DEPTH];
  bit          known [DEPTH];

  typedef struct {
    bit          wr;
    bit          rd;
    logic [15:0] addr;
    logic [63:0] wdata;
    bit          chk_rd;
    logic [63:0] exp_rd;
    string       tag;
  } vec_t;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // One request, started on a negedge with the DUT idle; returns on a negedge, idle.
  task automatic xact(input bit wr, input bit rd, input logic [15:0] addr,
                      input logic [63:0] wdata, input bit chk_rd,
                      input logic [63:0] exp_rd, input string tag);
    bit is_read;
    int exp_lat;
    is_read = rd && !wr;
    exp_lat = is_read ? int'(LAT) : wr_lat;
    readM   = rd;
    writeM  = wr;
    address = addr;
    tb_oe   = 1'b1;
    tb_drv  = wr ? wdata : PROBE;
    for (int n = 1; n <= exp_lat; n++) begin
      @(posedge clk);
      @(negedge clk);
      if (n < exp_lat) begin
        chk({tag, " ack_early"}, {63'd0, ack}, 64'd0);
        chk({tag, " busy_wait"}, {63'd0, busy}, 64'd1);
        if (is_read) begin
          chk({tag, " data_released"}, data, PROBE);
          if (n == exp_lat - 1) tb_oe = 1'b0;
        end
      end else begin
        chk({tag, " ack_on_time"}, {63'd0, ack}, 64'd1);
        if (is_read && chk_rd) chk({tag, " read_data"}, data, exp_rd);
        if (!is_read) chk({tag, " write_not_driven"}, data, wdata);
      end
    end
    readM  = 1'b0;
    writeM = 1'b0;
    if (wr) begin
      model[addr[9:2]] = wdata;
      known[addr[9:2]] = 1'b1;
    end
    tb_oe  = 1'b1;
    tb_drv = PROBE;
    @(posedge clk);
    @(negedge clk);
    chk({tag, " ack_single"}, {63'd0, ack}, 64'd0);
    chk({tag, " data_after_ack"}, data, PROBE);
`ifdef LINE_MEMORY_POSTED_WRITE_EN
    if (wr) begin
      repeat (LAT - 1) @(posedge clk);
      @(negedge clk);
    end
`endif
    chk({tag, " idle_busy"}, {63'd0, busy}, 64'd0);
  endtask

  vec_t vecs [8];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int first_ack;
    int second_ack;
    wr_lat = LAT;
`ifdef LINE_MEMORY_POSTED_WRITE_EN
    wr_lat = 1;
`endif
    for (int i = 0; i < int'(DEPTH); i++) known[i] = 1'b0;

    vecs[0] = '{1'b1, 1'b0, 16'h0044, 64'hAAAA_BBBB_CCCC_DDDD, 1'b0, 64'd0, "wr_0044"};
    vecs[1] = '{1'b0, 1'b1, 16'h0047, 64'd0, 1'b1, 64'hAAAA_BBBB_CCCC_DDDD, "rd_0047"};
    vecs[2] = '{1'b1, 1'b1, 16'h0008, 64'h0123_4567_89AB_CDEF, 1'b0, 64'd0, "wrrd_0008"};
    vecs[3] = '{1'b0, 1'b1, 16'h0008, 64'd0, 1'b1, 64'h0123_4567_89AB_CDEF, "rd_0008"};
    vecs[4] = '{1'b1, 1'b0, 16'h0400, 64'hFEDC_BA98_7654_3210, 1'b0, 64'd0, "wr_0400"};
    vecs[5] = '{1'b0, 1'b1, 16'h0000, 64'd0, 1'b1, 64'hFEDC_BA98_7654_3210, "rd_alias_0000"};
    vecs[6] = '{1'b1, 1'b0, 16'h03FC, 64'h8000_0000_0000_0001, 1'b0, 64'd0, "wr_top"};
    vecs[7] = '{1'b0, 1'b1, 16'hFFFF, 64'd0, 1'b1, 64'h8000_0000_0000_0001, "rd_top_alias"};

    reset   = 1'b1;
    readM   = 1'b0;
    writeM  = 1'b0;
    address = '0;
    tb_oe   = 1'b1;
    tb_drv  = PROBE;
    #1;
    chk("reset ack", {63'd0, ack}, 64'd0);
    chk("reset busy", {63'd0, busy}, 64'd0);
    chk("reset data", data, PROBE);
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;

    for (int i = 0; i < 8; i++)
      xact(vecs[i].wr, vecs[i].rd, vecs[i].addr, vecs[i].wdata,
           vecs[i].chk_rd, vecs[i].exp_rd, vecs[i].tag);

    // Reset in the middle of a write: no ack, no array update.
    xact(1'b1, 1'b0, 16'h0010, 64'h0BAD_F00D_0000_0010, 1'b0, 64'd0, "wr_prior_0010");
    writeM  = 1'b1;
    address = 16'h0010;
    tb_oe   = 1'b1;
    tb_drv  = 64'h1111_2222_3333_4444;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("abort busy_before", {63'd0, busy}, 64'd1);
    reset  = 1'b1;
    writeM = 1'b0;
    tb_drv = PROBE;
    #1;
    chk("abort ack_in_reset", {63'd0, ack}, 64'd0);
    chk("abort busy_in_reset", {63'd0, busy}, 64'd0);
    chk("abort data_in_reset", data, PROBE);
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    for (int n = 0; n < int'(LAT) + 3; n++) begin
      @(posedge clk);
      @(negedge clk);
      chk("abort no_ack", {63'd0, ack}, 64'd0);
    end
    xact(1'b0, 1'b1, 16'h0010, 64'd0, 1'b1, 64'h0BAD_F00D_0000_0010, "rd_after_abort");

    // Read held high across ACK: second request follows one idle cycle later.
    first_ack  = -1;
    second_ack = -1;
    tb_oe   = 1'b0;
    readM   = 1'b1;
    address = 16'h0045;
    for (int n = 1; n <= 2 * int'(LAT) + 2; n++) begin
      @(posedge clk);
      @(negedge clk);
      if (ack) begin
        chk("b2b read_data", data, model[8'h11]);
        if (first_ack < 0) first_ack = n;
        else if (second_ack < 0) second_ack = n;
      end
    end
    readM = 1'b0;
    chk("b2b first_ack", 64'(first_ack), 64'(LAT));
    chk("b2b gap", 64'(second_ack - first_ack), 64'(LAT + 1));
    @(posedge clk);
    @(negedge clk);
    chk("b2b idle_busy", {63'd0, busy}, 64'd0);

    // Randomized traffic on a small line pool with random alias bits.
    for (int i = 0; i < 40; i++) begin
      logic [7:0]  li;
      logic [15:0] a;
      logic [63:0] wd;
      li = 8'($urandom_range(0, 7) * 37);
      a  = {6'($urandom), li, 2'($urandom)};
      wd = {$urandom, $urandom};
      if (known[li] && ($urandom_range(0, 1) == 1))
        xact(1'b0, 1'b1, a, 64'd0, 1'b1, model[li], "rand_rd");
      else
        xact(1'b1, 1'b0, a, wd, 1'b0, 64'd0, "rand_wr");
    end

`ifdef LINE_MEMORY_POSTED_WRITE_EN
    // Posted write followed at once by a read of the same line.
    begin
      int rd_ack;
      rd_ack  = -1;
      writeM  = 1'b1;
      address = 16'h0100;
      tb_oe   = 1'b1;
      tb_drv  = 64'hC0FF_EE00_1234_5678;
      @(posedge clk);
      @(negedge clk);
      chk("posted wr_ack", {63'd0, ack}, 64'd1);
      writeM = 1'b0;
      readM  = 1'b1;
      tb_oe  = 1'b0;
      for (int n = 1; n <= 3 * int'(LAT); n++) begin
        @(posedge clk);
        @(negedge clk);
        if (ack && rd_ack < 0) begin
          rd_ack = n;
          readM  = 1'b0;
          chk("posted rd_data", data, 64'hC0FF_EE00_1234_5678);
        end
      end
      chk("posted rd_ack_time", 64'(rd_ack), 64'(2 * LAT));
      chk("posted idle_busy", {63'd0, busy}, 64'd0);
    end
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
